// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared constants and state encoding for the digit scan controller
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int MAX_WIDTH = 64;

    // Both buses are active-low, so "off" is all ones; callers slice to their width.
    localparam logic [MAX_WIDTH-1:0] SEG_OFF   = '1;
    localparam logic [MAX_WIDTH-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/display_scan_controller_slot_timer.sv
// rtl/display_scan_controller_slot_timer.sv - per-digit slot counter with dead-time and terminal flags
module display_scan_controller_slot_timer #(
    parameter  int SLOT_CYCLES  = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int CNT_W        = $clog2(SLOT_CYCLES)
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             clear,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             terminal,
    output logic             in_blank
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
        end else if (clear || terminal) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign terminal = (slot_cnt == CNT_LAST);
    assign in_blank = (slot_cnt < BLANK_END);

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - time-multiplexed seven-segment scan with dead-time and per-digit blink
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter  int DISPLAY_NUM  = 4,
    parameter  int SEG_WIDTH    = 8,
    parameter  int SLOT_CYCLES  = 50000,
    parameter  int BLANK_CYCLES = 16,
    parameter  int BLINK_FRAMES = 64,
    localparam int IDX_W        = $clog2(DISPLAY_NUM)
) (
    input  logic                             rst,
    input  logic                             clk,
    input  logic                             enable,
    input  logic [DISPLAY_NUM*SEG_WIDTH-1:0] displays_flattened,
    input  logic [DISPLAY_NUM-1:0]           blink_mask,
    output logic [SEG_WIDTH-1:0]             segments,
    output logic [DISPLAY_NUM-1:0]           anodes,
    output logic [IDX_W-1:0]                 scan_index,
    output logic                             frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0]       BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(DISPLAY_NUM - 1);
    localparam logic [FRM_W-1:0]       FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [SEG_WIDTH-1:0]   SEG_DARK   = SEG_OFF[SEG_WIDTH-1:0];
    localparam logic [DISPLAY_NUM-1:0] AN_DARK    = ANODE_OFF[DISPLAY_NUM-1:0];

    scan_state_t      state;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    logic [CNT_W-1:0] slot_cnt;
    logic             terminal;
    logic             in_blank;
    logic             timer_clear;

    logic                   show_edge;
    logic                   idx_last;
    logic                   cur_blinked;
    logic [SEG_WIDTH-1:0]   cur_pattern;
    logic [DISPLAY_NUM-1:0] cur_anode;

    // Holding the counter at zero while idle guarantees a full dead-time before the first digit.
    assign timer_clear = !enable || (state == ST_IDLE);

    display_scan_controller_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .rst      (rst),
        .clk      (clk),
        .clear    (timer_clear),
        .slot_cnt (slot_cnt),
        .terminal (terminal),
        .in_blank (in_blank)
    );

    assign show_edge   = in_blank && (slot_cnt == BLANK_LAST);
    assign idx_last    = (scan_index == IDX_LAST);
    assign cur_pattern = displays_flattened[scan_index*SEG_WIDTH +: SEG_WIDTH];
    assign cur_blinked = blink_phase && blink_mask[scan_index];
    assign cur_anode   = ~(DISPLAY_NUM'(1) << scan_index);

    // Pattern and blink decision are captured once per slot so mid-slot input changes cannot tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BLANK;
            scan_index  <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            segments    <= SEG_DARK;
            anodes      <= AN_DARK;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                scan_index <= '0;
                segments   <= SEG_DARK;
                anodes     <= AN_DARK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_BLANK;
                    end
                    ST_BLANK: begin
                        if (show_edge) begin
                            state <= ST_SHOW;
                            if (!cur_blinked) begin
                                segments <= cur_pattern;
                                anodes   <= cur_anode;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (terminal) begin
                            state    <= ST_BLANK;
                            segments <= SEG_DARK;
                            anodes   <= AN_DARK;
                            if (idx_last) begin
                                scan_index <= '0;
                                frame_done <= 1'b1;
                                if (frame_cnt == FRM_LAST) begin
                                    frame_cnt   <= '0;
                                    blink_phase <= ~blink_phase;
                                end else begin
                                    frame_cnt <= frame_cnt + 1'b1;
                                end
                            end else begin
                                scan_index <= scan_index + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        scan_index <= '0;
                        segments   <= SEG_DARK;
                        anodes     <= AN_DARK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;

    localparam int DN = 4;
    localparam int SW = 8;
    localparam int SC = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic          rst;
    logic          clk;
    logic          enable;
    logic [DN*SW-1:0] displays_flattened;
    logic [DN-1:0] blink_mask;
    logic [SW-1:0] segments;
    logic [DN-1:0] anodes;
    logic [1:0]    scan_index;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    vec_t tbl [17];

    display_scan_controller #(
        .DISPLAY_NUM  (DN),
        .SEG_WIDTH    (SW),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .rst                (rst),
        .clk                (clk),
        .enable             (enable),
        .displays_flattened (displays_flattened),
        .blink_mask         (blink_mask),
        .segments           (segments),
        .anodes             (anodes),
        .scan_index         (scan_index),
        .frame_done         (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] an, input logic [7:0] seg, input logic [1:0] idx);
        check({tag, ".anodes"}, 32'(anodes), 32'(an));
        check({tag, ".segments"}, 32'(segments), 32'(seg));
        check({tag, ".scan_index"}, 32'(scan_index), 32'(idx));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    // Continuous safety monitor: one-hot-or-none anodes and break-before-make between digits.
    int prev_lit = -1;
    int dark_run = 0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if ($countones(~anodes) > 1) begin
                errors++;
                $display("FAIL anodes_onehot cyc=%0d: got %b expected at most one low", cyc, anodes);
            end
            if (anodes != 4'b1111) begin
                int lit;
                lit = 0;
                for (int k = 0; k < DN; k++) if (!anodes[k]) lit = k;
                if (prev_lit >= 0 && lit != prev_lit) begin
                    checks++;
                    if (dark_run < BC) begin
                        errors++;
                        $display("FAIL break_before_make cyc=%0d: got %0d dark cycles expected >= %0d", cyc, dark_run, BC);
                    end
                end
                prev_lit = lit;
                dark_run = 0;
            end else begin
                dark_run++;
            end
        end else begin
            dark_run++;
        end
    end

    logic [5:0] blink_lit;

    initial begin
        tbl[0]  = '{0,  4'b1111, 8'hFF, 2'd0, 1'b0};
        tbl[1]  = '{1,  4'b1111, 8'hFF, 2'd0, 1'b0};
        tbl[2]  = '{2,  4'b1110, 8'h3F, 2'd0, 1'b0};
        tbl[3]  = '{7,  4'b1110, 8'h3F, 2'd0, 1'b0};
        tbl[4]  = '{8,  4'b1111, 8'hFF, 2'd1, 1'b0};
        tbl[5]  = '{9,  4'b1111, 8'hFF, 2'd1, 1'b0};
        tbl[6]  = '{10, 4'b1101, 8'h06, 2'd1, 1'b0};
        tbl[7]  = '{15, 4'b1101, 8'h06, 2'd1, 1'b0};
        tbl[8]  = '{16, 4'b1111, 8'hFF, 2'd2, 1'b0};
        tbl[9]  = '{18, 4'b1011, 8'h5B, 2'd2, 1'b0};
        tbl[10] = '{24, 4'b1111, 8'hFF, 2'd3, 1'b0};
        tbl[11] = '{26, 4'b0111, 8'h4F, 2'd3, 1'b0};
        tbl[12] = '{31, 4'b0111, 8'h4F, 2'd3, 1'b0};
        tbl[13] = '{32, 4'b1111, 8'hFF, 2'd0, 1'b1};
        tbl[14] = '{33, 4'b1111, 8'hFF, 2'd0, 1'b0};
        tbl[15] = '{34, 4'b1110, 8'h3F, 2'd0, 1'b0};
        tbl[16] = '{64, 4'b1111, 8'hFF, 2'd0, 1'b1};
        blink_lit = 6'b110011;

        rst                = 1'b0;
        enable             = 1'b1;
        displays_flattened = {8'h4F, 8'h5B, 8'h06, 8'h3F};
        blink_mask         = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state and full scan frame from the table
        check("reset.frame_done", 32'(frame_done), 32'd0);
        check_out("reset", 4'b1111, 8'hFF, 2'd0);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step_to(tbl[i].cyc);
            check_out($sformatf("scan[%0d]", tbl[i].cyc), tbl[i].an, tbl[i].seg, tbl[i].idx);
            check($sformatf("scan[%0d].frame_done", tbl[i].cyc), 32'(frame_done), 32'(tbl[i].fd));
        end

        // Mid-SHOW input change must wait for the next frame
        do_reset();
        step_to(12);
        displays_flattened[15:8] = 8'h66;
        step_to(13);
        check_out("tear.same_slot", 4'b1101, 8'h06, 2'd1);
        step_to(42);
        check_out("tear.next_frame", 4'b1101, 8'h66, 2'd1);
        displays_flattened[15:8] = 8'h06;

        // Blink digit 1: two frames lit, two dark, two lit
        do_reset();
        blink_mask = 4'b0010;
        for (int f = 0; f < 6; f++) begin
            step_to(32 * f + 12);
            if (blink_lit[f])
                check_out($sformatf("blink.f%0d.d1", f), 4'b1101, 8'h06, 2'd1);
            else
                check_out($sformatf("blink.f%0d.d1", f), 4'b1111, 8'hFF, 2'd1);
            step_to(32 * f + 20);
            check_out($sformatf("blink.f%0d.d2", f), 4'b1011, 8'h5B, 2'd2);
        end
        blink_mask = 4'b0000;

        // Enable drop during digit 2, then re-enable
        do_reset();
        step_to(20);
        check_out("en.before", 4'b1011, 8'h5B, 2'd2);
        enable = 1'b0;
        step_to(21);
        check_out("en.dropped", 4'b1111, 8'hFF, 2'd0);
        step_to(22);
        check_out("en.idle", 4'b1111, 8'hFF, 2'd0);
        enable = 1'b1;
        step_to(23);
        check_out("en.blank0", 4'b1111, 8'hFF, 2'd0);
        check("en.blank0.frame_done", 32'(frame_done), 32'd0);
        step_to(24);
        check_out("en.blank1", 4'b1111, 8'hFF, 2'd0);
        step_to(25);
        check_out("en.first_lit", 4'b1110, 8'h3F, 2'd0);

        // Asynchronous reset during digit 3
        do_reset();
        step_to(28);
        check_out("rst.before", 4'b0111, 8'h4F, 2'd3);
        #2;
        rst = 1'b0;
        #1;
        check_out("rst.async", 4'b1111, 8'hFF, 2'd0);
        check("rst.async.frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        step_to(1);
        check_out("rst.restart_dark", 4'b1111, 8'hFF, 2'd0);
        step_to(2);
        check_out("rst.restart_lit", 4'b1110, 8'h3F, 2'd0);
        step_to(10);
        check_out("rst.restart_d1", 4'b1101, 8'h06, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed driver that shares one physical 8-bit segment bus among DISPLAY_NUM seven-segment digits. It sits downstream of the device-array top level, consumes its packed per-device display bytes ({dot, 7 segments}, active-low), and sequences anode enables with a dead-time blank between digits. It also supports per-digit blinking so the selected device can be highlighted.

## Interface
- DISPLAY_NUM, 4, number of multiplexed digits (≥2)
- SEG_WIDTH, 8, bits per digit pattern, {dot, g..a}, active-low
- SLOT_CYCLES, 50000, clk cycles per digit slot (blank + show)
- BLANK_CYCLES, 16, dead-time cycles at start of each slot; 1 ≤ BLANK_CYCLES < SLOT_CYCLES
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1)
- rst  input  1  reset, asynchronous, active-low
- clk  input  1  clock
- enable  input  1  scanning enabled; low blanks all digits
- displays_flattened  input  DISPLAY_NUM*SEG_WIDTH  digit j at bits [j*SEG_WIDTH +: SEG_WIDTH]
- blink_mask  input  DISPLAY_NUM  1 = digit blinks
- segments  output  SEG_WIDTH  shared segment bus, active-low (all 1 = dark)
- anodes  output  DISPLAY_NUM  digit enables, active-low, at most one low
- scan_index  output  clog2(DISPLAY_NUM)  digit owning current slot
- frame_done  output  1  one-cycle pulse at end of each full frame

## Operation
- FSM states: IDLE, BLANK, SHOW. Reset → BLANK, scan_index=0, slot_cnt=0, frame_cnt=0, blink_phase=0.
- Reset outputs: segments=all 1, anodes=all 1, scan_index=0, frame_done=0.
- slot_cnt counts 0..SLOT_CYCLES-1 per slot. BLANK while slot_cnt<BLANK_CYCLES; SHOW otherwise.
- BLANK: anodes all 1, segments all 1.
- BLANK→SHOW: latch displays_flattened[scan_index] into pattern register; input changes during SHOW have no effect until next slot (no tearing).
- SHOW: anodes[scan_index]=0, segments=pattern, unless blink_phase=1 and blink_mask[scan_index]=1 → anodes all 1, segments all 1 (blinked digit fully dark).
- blink_mask is sampled at the same BLANK→SHOW edge as the pattern.
- SHOW end (slot_cnt=SLOT_CYCLES-1): slot_cnt→0, scan_index increments, wrapping DISPLAY_NUM-1→0; next state BLANK.
- Wrap to 0: frame_done=1 for that one cycle; frame_cnt increments; when frame_cnt reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
- enable low (any state): next cycle IDLE, outputs dark, scan_index=0, slot_cnt=0; frame_cnt and blink_phase hold.
- IDLE with enable high: next cycle BLANK, slot_cnt=0, index 0 (full dead-time always precedes first digit).
- Reset mid-slot: immediate return to reset values, asynchronously.

## Timing
- All outputs are Moore outputs decoded from registers only; no combinational path from any input to any output.
- After reset release: cycles 0..BLANK_CYCLES-1 dark; cycle BLANK_CYCLES anode 0 low with pattern captured at that edge.
- Each digit is lit SLOT_CYCLES-BLANK_CYCLES cycles per frame; frame period DISPLAY_NUM*SLOT_CYCLES cycles.
- Break-before-make: between any two lit digits, ≥BLANK_CYCLES cycles with all anodes high.
- enable deassertion → outputs dark within 1 cycle.
- frame_done is asserted in the first BLANK cycle of slot 0.

## Structure
- Shared package: SEG_OFF constant (all ones), ANODE_OFF helper, state enumeration {IDLE, BLANK, SHOW}.
- Sub-module slot_timer: slot_cnt counter with clear, terminal-count and in_blank outputs; the FSM, index, blink logic and output registers live in the top of this block.

## Test plan
- Parameters DISPLAY_NUM=4, SLOT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2; inputs 0x3F/0x06/0x5B/0x4F, enable=1 → anodes 1110,1101,1011,0111 each for 6 cycles after 2 dark cycles; segments match; frame_done every 32 cycles.
- Change digit 1 input to 0x66 mid-SHOW of slot 1 → segments stay 0x06 this slot, show 0x66 next frame.
- blink_mask=0010 → digit 1 lit in frames 0–1, dark in frames 2–3, lit in frames 4–5; other digits unaffected.
- Drop enable during SHOW of digit 2 → next cycle anodes=1111, segments=0xFF; re-enable → 2 dark cycles then anode 0 low.
- Assert rst during SHOW of digit 3 → anodes=1111, segments=0xFF, scan_index=0 immediately; after release sequence restarts at digit 0.
- Across all runs assert: never more than one anode low; ≥2 all-high cycles between different lit digits.
